fetch: RTL and testbench

Instruction fetch stage for the Pillar RV32 core, directly upstream of `decode`. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. Each returned word is registered as the instruction register (IR) and presented to `decode`'s `ir_i` with a valid/ready handshake. Branch and jump redirects from the execute side are accepted at any time; a redirect that arrives while a read is outstanding drains that read and discards its data.

---
 rtl/fetch.sv | 137 +++++++++++++
 tb/tb_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Pillar RV32 instruction fetch: PC, imem req/ack, IR hand-off to decode.
// Redirects during an outstanding read drain that read before retargeting.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic        ir_valid_o,
    input  logic        ir_ready_i,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN,
        FAULT
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_pc_q;
    logic [31:0] ir_q;
    logic [31:0] pc_out_q;
    logic [31:0] count_q;
    logic        valid_q;
    logic        fault_q;

    logic [31:0] drain_tgt_d;
    logic        redir_bad_d;
    logic        drain_bad_d;

    // A redirect landing together with the drain ack is the newest target.
    assign drain_tgt_d = redirect_i ? redirect_pc_i : pend_pc_q;
    assign redir_bad_d = redirect_pc_i[1:0] != 2'b00;
    assign drain_bad_d = drain_tgt_d[1:0] != 2'b00;

    assign imem_req_o    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr_o   = pc_q;
    assign ir_o          = ir_q;
    assign pc_o          = pc_out_q;
    assign ir_valid_o    = valid_q;
    assign fault_o       = fault_q;
    assign fetch_count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            ir_q      <= NOP;
            pc_out_q  <= RESET_PC;
            count_q   <= 32'd0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_i && redir_bad_d) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        if (redirect_i) pc_q <= redirect_pc_i;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect_i && !imem_ack_i) begin
                        pend_pc_q <= redirect_pc_i;
                        state_q   <= DRAIN;
                    end else if (redirect_i) begin
                        if (redir_bad_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q    <= redirect_pc_i;
                            state_q <= FETCH;
                        end
                    end else if (imem_ack_i) begin
                        ir_q     <= imem_rdata_i;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        valid_q <= 1'b0;
                        if (redir_bad_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q    <= redirect_pc_i;
                            state_q <= FETCH;
                        end
                    end else if (ir_ready_i) begin
                        valid_q <= 1'b0;
                        count_q <= count_q + 32'd1;
                        state_q <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) begin
                        if (drain_bad_d) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q    <= drain_tgt_d;
                            state_q <= FETCH;
                        end
                    end else if (redirect_i) begin
                        pend_pc_q <= redirect_pc_i;
                    end
                end
                FAULT: begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: directed phases, monitor checks deliveries.
// Memory model answers each word with addr + 0xA0.
module tb_fetch;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        fault;
    logic [31:0] fetch_count;

    logic        ack_en;
    exp_t        sb[$];
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && ack_en;
    assign imem_rdata = imem_addr + 32'h0000_00A0;

    fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ir_o          (ir),
        .pc_o          (pc),
        .ir_valid_o    (ir_valid),
        .ir_ready_i    (ir_ready),
        .fault_o       (fault),
        .fetch_count_o (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] c);
        exp_t e;
        e.ir  = i;
        e.pc  = p;
        e.cnt = c;
        sb.push_back(e);
    endtask

    // Monitor: every completed handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && ir_valid && ir_ready && !redirect) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_delivery: ir=%h pc=%h", ir, pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deliver_ir", ir, e.ir);
                chk("deliver_pc", pc, e.pc);
                chk("deliver_cnt", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ir_ready    = 1'b1;
        ack_en      = 1'b1;

        // reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_ir", ir, 32'h13);
        end
        chk("rst_pc", pc, 32'h100);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_cnt", fetch_count, 32'd0);
        reset = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);

        // zero-wait streaming
        push(32'h1A0, 32'h100, 32'd0);
        push(32'h1A4, 32'h104, 32'd1);
        push(32'h1A8, 32'h108, 32'd2);
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stream_valid", {31'd0, ir_valid}, 32'd1);
            chk("stream_ir", ir, 32'h1A0 + 32'(4 * i));
            step();
            chk("stream_cnt", fetch_count, 32'(i + 1));
            chk("stream_addr", imem_addr, 32'h104 + 32'(4 * i));
        end

        // backpressure
        ir_ready = 1'b0;
        push(32'h1AC, 32'h10C, 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ir", ir, 32'h1AC);
            chk("bp_pc", pc, 32'h10C);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_cnt", fetch_count, 32'd3);
        end
        ir_ready = 1'b1;
        step();
        chk("bp_rel_cnt", fetch_count, 32'd4);
        chk("bp_rel_addr", imem_addr, 32'h110);

        // redirect in HOLD with ready in the same cycle
        step();
        chk("hold_valid", {31'd0, ir_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("rh_valid", {31'd0, ir_valid}, 32'd0);
        chk("rh_cnt", fetch_count, 32'd4);
        chk("rh_req", {31'd0, imem_req}, 32'd1);
        chk("rh_addr", imem_addr, 32'h200);

        // redirect while a request is outstanding
        push(32'h2A0, 32'h200, 32'd4);
        step();
        ack_en = 1'b0;
        step();
        chk("pre_drain_addr", imem_addr, 32'h204);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            redirect = 1'b0;
            chk("drain_addr", imem_addr, 32'h204);
            chk("drain_req", {31'd0, imem_req}, 32'd1);
            chk("drain_valid", {31'd0, ir_valid}, 32'd0);
        end
        ack_en = 1'b1;
        push(32'h3A0, 32'h300, 32'd5);
        step();
        chk("post_drain_addr", imem_addr, 32'h300);
        chk("post_drain_valid", {31'd0, ir_valid}, 32'd0);
        chk("post_drain_cnt", fetch_count, 32'd5);
        step();
        chk("tgt_ir", ir, 32'h3A0);
        step();
        chk("tgt_cnt", fetch_count, 32'd6);

        // misaligned redirect, fault is sticky
        redirect    = 1'b1;
        redirect_pc = 32'h202;
        step();
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_req", {31'd0, imem_req}, 32'd0);
        chk("fault_valid", {31'd0, ir_valid}, 32'd0);
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("fault_hold", {31'd0, fault}, 32'd1);
            chk("fault_noreq", {31'd0, imem_req}, 32'd0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_cnt", fetch_count, 32'd0);
        chk("clr_ir", ir, 32'h13);
        step();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h100);

        ack_en   = 1'b0;
        ir_ready = 1'b0;
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
